// File: rtl/nvdla_sdp_rdma_pkg.sv
// Shared types and constants for the SDP RDMA layer sequencer.
// Optional watchdog state is present only when NVDLA_SDP_RDMA_WDT_EN is defined.
package nvdla_sdp_rdma_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_CNT_W  = 32;

  localparam int unsigned CH_MRDMA = 0;
  localparam int unsigned CH_BRDMA = 1;
  localparam int unsigned CH_NRDMA = 2;
  localparam int unsigned CH_ERDMA = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RUN      = 3'd1,
    ST_DONE     = 3'd2,
    ST_WAIT_CLR = 3'd3
`ifdef NVDLA_SDP_RDMA_WDT_EN
    ,
    ST_TIMEOUT  = 3'd4
`endif
  } layer_state_e;

endpackage

// File: rtl/nvdla_sdp_rdma_ch_track.sv
// Per-engine tracker: latched disable, done-pending bit, completion latency and
// sticky spurious-done flag. All state is reloaded on layer start.
module nvdla_sdp_rdma_ch_track
  import nvdla_sdp_rdma_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_run,
  input  logic             i_op_en,
  input  logic             i_dis,
  input  logic             i_done,
  input  logic [CNT_W-1:0] i_cycles,
  output logic             o_op_en_c,
  output logic             o_acc_c,
  output logic             o_pending,
  output logic             o_dis_q,
  output logic [CNT_W-1:0] o_lat,
  output logic             o_err
);

  logic             r_dis_q;
  logic             r_pending;
  logic [CNT_W-1:0] r_lat;
  logic             r_err;
  logic             w_eligible;

  // An engine finishing in the same cycle op_en drops still counts as accepted,
  // so completion can win over abort.
  assign w_eligible = i_run & ~r_pending & ~r_dis_q;
  assign o_op_en_c  = w_eligible & i_op_en;
  assign o_acc_c    = w_eligible & i_done;

  // Engine bookkeeping, cleared when a new layer starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dis_q   <= 1'b0;
      r_pending <= 1'b0;
      r_lat     <= '0;
      r_err     <= 1'b0;
    end else if (i_start) begin
      r_dis_q   <= i_dis;
      r_pending <= 1'b0;
      r_lat     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (o_acc_c) begin
        r_pending <= 1'b1;
        r_lat     <= i_cycles;
      end
      if (i_done && !o_acc_c) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_pending = r_pending;
  assign o_dis_q   = r_dis_q;
  assign o_lat     = r_lat;
  assign o_err     = r_err;

endmodule

// File: rtl/nvdla_sdp_rdma_layer_ctrl.sv
// SDP RDMA layer sequencer: gates engine op_en, collects per-engine dones and
// emits a single layer-done pulse. Watchdog under NVDLA_SDP_RDMA_WDT_EN.
module nvdla_sdp_rdma_layer_ctrl
  import nvdla_sdp_rdma_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rstn,
  input  logic                    reg2dp_op_en,
  input  logic [NUM_CH-1:0]       ch_disable,
  input  logic [NUM_CH-1:0]       ch_done,
`ifdef NVDLA_SDP_RDMA_WDT_EN
  input  logic [CNT_W-1:0]        reg2dp_wdt_limit,
  output logic                    dp2reg_timeout,
`endif
  output logic [NUM_CH-1:0]       ch_op_en,
  output logic                    dp2reg_done,
  output logic [CNT_W-1:0]        dp2reg_layer_cycles,
  output logic [NUM_CH*CNT_W-1:0] dp2reg_ch_lat,
  output logic [NUM_CH-1:0]       dp2reg_err_spurious,
  output logic                    layer_busy,
  output logic                    layer_abort
);

  layer_state_e      r_state;
  layer_state_e      w_state_nxt;
  logic              w_abort;
  logic              w_start;
  logic              w_run;
  logic              w_complete;
  logic [CNT_W-1:0]  r_layer_cycles;
  logic              r_done;
  logic              r_busy;
  logic              r_abort;
  logic [NUM_CH-1:0] w_acc;
  logic [NUM_CH-1:0] w_pending;
  logic [NUM_CH-1:0] w_dis_q;
`ifdef NVDLA_SDP_RDMA_WDT_EN
  logic              r_timeout;
  logic              w_wdt_hit;
`endif

  assign w_start    = (r_state == ST_IDLE) & reg2dp_op_en;
  assign w_run      = (r_state == ST_RUN);
  assign w_complete = &(w_pending | w_acc | w_dis_q);

`ifdef NVDLA_SDP_RDMA_WDT_EN
  assign w_wdt_hit  = (reg2dp_wdt_limit != '0) && (r_layer_cycles == reg2dp_wdt_limit);
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nvdla_sdp_rdma_ch_track #(.CNT_W(CNT_W)) u_track (
      .clk       (nvdla_core_clk),
      .rst_n     (nvdla_core_rstn),
      .i_start   (w_start),
      .i_run     (w_run),
      .i_op_en   (reg2dp_op_en),
      .i_dis     (ch_disable[g]),
      .i_done    (ch_done[g]),
      .i_cycles  (r_layer_cycles),
      .o_op_en_c (ch_op_en[g]),
      .o_acc_c   (w_acc[g]),
      .o_pending (w_pending[g]),
      .o_dis_q   (w_dis_q[g]),
      .o_lat     (dp2reg_ch_lat[g*CNT_W +: CNT_W]),
      .o_err     (dp2reg_err_spurious[g])
    );
  end

  // Layer state register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_state <= ST_IDLE;
    else                  r_state <= w_state_nxt;
  end

  // Next-state logic; completion beats abort, abort beats watchdog.
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE:     if (reg2dp_op_en) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_complete) begin
          w_state_nxt = ST_DONE;
        end else if (!reg2dp_op_en) begin
          w_state_nxt = ST_IDLE;
          w_abort     = 1'b1;
        end
`ifdef NVDLA_SDP_RDMA_WDT_EN
        else if (w_wdt_hit) begin
          w_state_nxt = ST_TIMEOUT;
        end
`endif
      end
      ST_DONE:     w_state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR: if (!reg2dp_op_en) w_state_nxt = ST_IDLE;
`ifdef NVDLA_SDP_RDMA_WDT_EN
      ST_TIMEOUT:  w_state_nxt = ST_WAIT_CLR;
`endif
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // RUN-cycle counter, saturating, cleared on layer start.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_layer_cycles <= '0;
    end else if (w_start) begin
      r_layer_cycles <= '0;
    end else if (w_run && (r_layer_cycles != '1)) begin
      r_layer_cycles <= r_layer_cycles + CNT_W'(1);
    end
  end

  // Registered status outputs, derived from the next state.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_DONE) ||
                 (w_state_nxt == ST_WAIT_CLR);
      r_abort <= w_abort;
    end
  end

`ifdef NVDLA_SDP_RDMA_WDT_EN
  // Watchdog expiry pulse.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) r_timeout <= 1'b0;
    else                  r_timeout <= (w_state_nxt == ST_TIMEOUT);
  end
  assign dp2reg_timeout = r_timeout;
`endif

  assign dp2reg_done         = r_done;
  assign dp2reg_layer_cycles = r_layer_cycles;
  assign layer_busy          = r_busy;
  assign layer_abort         = r_abort;

endmodule
